// File: rtl/byte_inc_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | byte_inc_sched_pkg : shared state encoding and job record for the sched  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package byte_inc_sched_pkg;

    // Sized for the largest requester count (8) and the widest address (16).
    localparam int ID_W       = 3;
    localparam int ADDR_W_MAX = 16;
    localparam int STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_ACK    = 3'd3,
        ST_BUSY   = 3'd4,
        ST_DONE   = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [ADDR_W_MAX-1:0] base_addr;
        logic [ADDR_W_MAX-1:0] length;
    } job_t;

endpackage
`default_nettype wire

// File: rtl/byte_inc_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | byte_inc_sched_if : requester job post / completion bus                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface byte_inc_sched_if #(
    parameter int REQ_CNT    = 4,
    parameter int ADDR_WIDTH = 10
);
    logic [REQ_CNT-1:0]            req_valid;
    logic [REQ_CNT-1:0]            req_ready;
    logic [REQ_CNT*ADDR_WIDTH-1:0] req_base_addr;
    logic [REQ_CNT*ADDR_WIDTH-1:0] req_length;
    logic [REQ_CNT-1:0]            done;
    logic [REQ_CNT-1:0]            err;

    modport master (
        output req_valid, req_base_addr, req_length,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_base_addr, req_length,
        output req_ready, done, err
    );
endinterface
`default_nettype wire

// File: rtl/byte_inc_sched_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | byte_inc_sched_rr_arbiter : combinational round-robin pick from ptr_i    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module byte_inc_sched_rr_arbiter
    import byte_inc_sched_pkg::*;
#(
    parameter int REQ_CNT = 4
) (
    input  wire  [REQ_CNT-1:0] req_i,
    input  wire  [ID_W-1:0]    ptr_i,
    output logic [REQ_CNT-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);
    localparam int              c_sum_w   = ID_W + 1;
    localparam logic [ID_W:0]   c_req_cnt = c_sum_w'(REQ_CNT);

    logic [REQ_CNT-1:0] w_rot;
    logic               w_found;
    logic [ID_W:0]      w_off;
    logic [ID_W:0]      w_sum;

    // Rotating the doubled vector puts requester ptr_i at bit 0.
    assign w_rot = REQ_CNT'({req_i, req_i} >> ptr_i);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < REQ_CNT; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = c_sum_w'(k);
            end
        end
        w_sum = {1'b0, ptr_i} + w_off;
        if (w_sum >= c_req_cnt) begin
            w_sum = w_sum - c_req_cnt;
        end
    end

    assign valid_o = w_found;
    assign idx_o   = w_sum[ID_W-1:0];
    assign grant_o = w_found ? (REQ_CNT'(1) << w_sum[ID_W-1:0]) : '0;

endmodule
`default_nettype wire

// File: rtl/byte_inc_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | byte_inc_sched : round-robin job scheduler in front of one byte_inc      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module byte_inc_sched
    import byte_inc_sched_pkg::*;
#(
    parameter int REQ_CNT     = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_LEN     = 2**ADDR_WIDTH - 1
) (
    input  wire                         clk_i,
    input  wire                         srst_i,
    byte_inc_sched_if.slave             req_if,
    output logic                        busy_o,
    output logic [$clog2(REQ_CNT)-1:0]  cur_id_o,
    output logic                        eng_run_o,
    output logic [ADDR_WIDTH-1:0]       eng_base_addr_o,
    output logic [ADDR_WIDTH-1:0]       eng_length_o,
    input  wire                         eng_waitrequest_i
);
    localparam int                     c_cur_id_w  = $clog2(REQ_CNT);
    localparam int                     c_tmo_w     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0]     c_ack_tmo   = c_tmo_w'(ACK_TIMEOUT);
    localparam logic [ADDR_W_MAX-1:0]  c_max_len   = ADDR_W_MAX'(MAX_LEN);
    localparam logic [ID_W-1:0]        c_last_id   = ID_W'(REQ_CNT - 1);

    localparam logic [STATE_W-1:0] c_st_idle   = ST_IDLE;
    localparam logic [STATE_W-1:0] c_st_check  = ST_CHECK;
    localparam logic [STATE_W-1:0] c_st_launch = ST_LAUNCH;
    localparam logic [STATE_W-1:0] c_st_ack    = ST_ACK;
    localparam logic [STATE_W-1:0] c_st_busy   = ST_BUSY;
    localparam logic [STATE_W-1:0] c_st_done   = ST_DONE;

    logic [STATE_W-1:0] state_q, state_d;
    logic [ID_W-1:0]    ptr_q,   ptr_d;
    job_t               job_q,   job_d;
    logic [c_tmo_w-1:0] cnt_q,   cnt_d;

    logic [REQ_CNT-1:0]    w_grant;
    logic [ID_W-1:0]       w_grant_idx;
    logic                  w_arb_valid;
    logic [ADDR_WIDTH-1:0] w_sel_base;
    logic [ADDR_WIDTH-1:0] w_sel_len;
    logic [REQ_CNT-1:0]    w_id_oh;
    logic [c_tmo_w-1:0]    w_cnt_inc;
    logic [REQ_CNT-1:0]    w_ready;
    logic [REQ_CNT-1:0]    w_done;
    logic [REQ_CNT-1:0]    w_err;
    logic                  w_run;
    logic                  w_unused;

    byte_inc_sched_rr_arbiter #(
        .REQ_CNT (REQ_CNT)
    ) u_arb (
        .req_i   (req_if.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_grant_idx),
        .valid_o (w_arb_valid)
    );

    always_comb begin
        w_sel_base = '0;
        w_sel_len  = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            if (w_grant[i]) begin
                w_sel_base = req_if.req_base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_len  = req_if.req_length[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign w_id_oh   = REQ_CNT'(1) << job_q.id;
    assign w_cnt_inc = (cnt_q == c_ack_tmo) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        job_d   = job_q;
        cnt_d   = cnt_q;
        w_ready = '0;
        w_done  = '0;
        w_err   = '0;
        w_run   = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (w_arb_valid) begin
                    w_ready         = w_grant;
                    job_d.id        = w_grant_idx;
                    job_d.base_addr = ADDR_W_MAX'(w_sel_base);
                    job_d.length    = ADDR_W_MAX'(w_sel_len);
                    ptr_d           = (w_grant_idx == c_last_id) ? '0 : w_grant_idx + 1'b1;
                    state_d         = c_st_check;
                end
            end
            c_st_check: begin
                if (job_q.length == '0) begin
                    w_done  = w_id_oh;
                    state_d = c_st_idle;
                end else if (job_q.length > c_max_len) begin
                    w_err   = w_id_oh;
                    state_d = c_st_idle;
                end else begin
                    state_d = c_st_launch;
                end
            end
            c_st_launch: begin
                if (!eng_waitrequest_i) begin
                    w_run   = 1'b1;
                    cnt_d   = '0;
                    state_d = c_st_ack;
                end
            end
            c_st_ack: begin
                // The error fires in the cycle the count reaches the limit,
                // i.e. ACK_TIMEOUT cycles after the run pulse.
                if (eng_waitrequest_i) begin
                    state_d = c_st_busy;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_ack_tmo) begin
                        w_err   = w_id_oh;
                        state_d = c_st_idle;
                    end
                end
            end
            c_st_busy: begin
                if (!eng_waitrequest_i) begin
                    state_d = c_st_done;
                end
            end
            c_st_done: begin
                w_done  = w_id_oh;
                state_d = c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q <= c_st_idle;
            ptr_q   <= '0;
            job_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            job_q   <= job_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_if.req_ready = w_ready;
    assign req_if.done      = w_done;
    assign req_if.err       = w_err;
    assign busy_o           = (state_q != c_st_idle);
    assign cur_id_o         = busy_o ? job_q.id[c_cur_id_w-1:0] : '0;
    assign eng_run_o        = w_run;
    assign eng_base_addr_o  = w_run ? job_q.base_addr[ADDR_WIDTH-1:0] : '0;
    assign eng_length_o     = w_run ? job_q.length[ADDR_WIDTH-1:0] : '0;

    // Package-wide field widths leave upper bits idle for small configs.
    assign w_unused = ^{job_q.base_addr, job_q.id};

endmodule
`default_nettype wire
